unit_mod_counter: RTL and testbench

Parametrised modulo time-unit counter with BCD digit editing, time-zone offset shifting and carry/borrow cascade pulses. It generalises the fixed 24-hour counter into a single block that serves hours, minutes or seconds by setting `MODULUS`. The block sits between the tick generator and the display/day logic of the digital clock. Instances chain through `carry_out`/`borrow_out` into the next unit's `carry_in`/`borrow_in`.

---
 rtl/clock_pkg.sv | 22 ++
 rtl/unit_mod_counter_if.sv | 41 ++++
 rtl/unit_mod_counter_digit_split.sv | 36 +++
 rtl/unit_mod_counter.sv | 236 +++++++++++++++++++++++
 tb/tb_unit_mod_counter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock time-unit counters.
//   op_e        : operation code registered by the decode stage and
//                 consumed by the execute stage of unit_mod_counter.
//   DIGIT_RADIX : decimal radix used for tens/ones digit handling.
package clock_pkg;

  typedef enum logic [3:0] {
    OP_NONE     = 4'd0,
    OP_UP       = 4'd1,
    OP_DOWN     = 4'd2,
    OP_OFS_ADD  = 4'd3,
    OP_OFS_SUB  = 4'd4,
    OP_ONES_INC = 4'd5,
    OP_ONES_DEC = 4'd6,
    OP_TENS_INC = 4'd7,
    OP_TENS_DEC = 4'd8,
    OP_HALF     = 4'd9
  } op_e;

  localparam int unsigned DIGIT_RADIX = 32'd10;

endpackage

// File: rtl/unit_mod_counter_if.sv
// Request/response bundle of one time-unit counter.
//   master : the controlling side (tick generator, editor, neighbour units)
//            drives the requests and observes value and pulses.
//   slave  : the counter itself.
// Requests : tick, edit_en, inc, dec, digit_sel, carry_in, borrow_in,
//            ofs_valid, ofs_neg, ofs_val[WIDTH], mode12, half_toggle.
// Responses: value[WIDTH], carry_out, borrow_out, err.
interface unit_mod_counter_if #(
  parameter int WIDTH = 7
) ();

  logic             tick;
  logic             edit_en;
  logic             inc;
  logic             dec;
  logic             digit_sel;
  logic             carry_in;
  logic             borrow_in;
  logic             ofs_valid;
  logic             ofs_neg;
  logic [WIDTH-1:0] ofs_val;
  logic             mode12;
  logic             half_toggle;
  logic [WIDTH-1:0] value;
  logic             carry_out;
  logic             borrow_out;
  logic             err;

  modport master (
    output tick, edit_en, inc, dec, digit_sel, carry_in, borrow_in,
           ofs_valid, ofs_neg, ofs_val, mode12, half_toggle,
    input  value, carry_out, borrow_out, err
  );

  modport slave (
    input  tick, edit_en, inc, dec, digit_sel, carry_in, borrow_in,
           ofs_valid, ofs_neg, ofs_val, mode12, half_toggle,
    output value, carry_out, borrow_out, err
  );

endinterface

// File: rtl/unit_mod_counter_digit_split.sv
// digit_split: combinational binary-to-decimal-digit split.
//   value [WIDTH] in  : binary count
//   tens  [WIDTH] out : value / 10
//   ones  [4]     out : value % 10
// Also used by the display path.
module digit_split
  import clock_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] tens,
  output logic [3:0]       ones
);

  // Four spare bits keep the radix constant representable for tiny WIDTH.
  localparam int XW = WIDTH + 4;
  localparam logic [XW-1:0] RADIX_X = XW'(DIGIT_RADIX);

  logic [XW-1:0] ext_s;
  logic [XW-1:0] quo_s;
  logic [XW-1:0] rem_s;
  logic          unused_s;

  // Divide by the radix; the remainder is the ones digit.
  always_comb begin
    ext_s = XW'(value);
    quo_s = ext_s / RADIX_X;
    rem_s = ext_s - (quo_s * RADIX_X);
  end

  assign tens     = quo_s[WIDTH-1:0];
  assign ones     = rem_s[3:0];
  assign unused_s = &{1'b0, quo_s[XW-1:WIDTH], rem_s[XW-1:4]};

endmodule

// File: rtl/unit_mod_counter.sv
// unit_mod_counter: modulo-MODULUS time-unit counter (hours/minutes/seconds)
// with BCD digit editing, signed offset shifting and carry/borrow pulses.
//   clk   in : clock
//   reset in : synchronous active-high reset
//   bus      : unit_mod_counter_if.slave (requests in, value/pulses out)
// Two stages: decode arbitrates the requests into one registered op code,
// execute applies it to the registered value and registers the pulses.
// Optional build macro UNIT_MOD_COUNTER_HALF12_EN adds 12-hour editing
// (mode12 / half_toggle); without it those inputs are ignored.
module unit_mod_counter
  import clock_pkg::*;
#(
  parameter int MODULUS = 24,
  parameter int WIDTH   = 7
) (
  input  logic            clk,
  input  logic            reset,
  unit_mod_counter_if.slave bus
);

  // Internal arithmetic width: at least WIDTH+1, and never below 8 so the
  // radix and all sums up to 2*MODULUS stay representable.
  localparam int XW = (WIDTH >= 7) ? (WIDTH + 1) : 8;
  localparam logic [XW-1:0] ZERO_X  = XW'(0);
  localparam logic [XW-1:0] ONE_X   = XW'(1);
  localparam logic [XW-1:0] MOD_X   = XW'(MODULUS);
  localparam logic [XW-1:0] RADIX_X = XW'(DIGIT_RADIX);
  localparam logic [XW-1:0] NINE_X  = XW'(DIGIT_RADIX - 1);

  op_e              op_s;
  op_e              op_r;
  logic [WIDTH-1:0] ofs_r;
  logic [WIDTH-1:0] value_r;
  logic             carry_r;
  logic             borrow_r;
  logic             err_r;

  logic [WIDTH-1:0] tens_s;
  logic [3:0]       ones_s;

  logic [XW-1:0] v_s;
  logic [XW-1:0] ofs_x_s;
  logic [XW-1:0] ones_x_s;
  logic [XW-1:0] base_s;
  logic [XW-1:0] room_s;
  logic [XW-1:0] lim_s;
  logic [XW-1:0] sum_s;
  logic [XW-1:0] tdk_s;
  logic [XW-1:0] ones_inc_s;
  logic [XW-1:0] ones_dec_s;
  logic [XW-1:0] tens_inc_s;
  logic [XW-1:0] tens_dec_s;
  logic [XW-1:0] nxt_s;
  logic          carry_s;
  logic          borrow_s;
  logic          err_s;
  logic          unused_s;

`ifdef UNIT_MOD_COUNTER_HALF12_EN
  localparam logic [XW-1:0] HALF_X = XW'(MODULUS / 2);
  logic          mode12_r;
  logic [XW-1:0] half_lo_s;
  logic [XW-1:0] half_hi_s;
  logic [XW-1:0] half_inc_s;
  logic [XW-1:0] half_dec_s;
  logic [XW-1:0] half_flip_s;
`endif

  digit_split #(.WIDTH(WIDTH)) u_digit_split (
    .value (value_r),
    .tens  (tens_s),
    .ones  (ones_s)
  );

  // Stage 1: fixed-priority arbitration; losing requests are dropped.
  always_comb begin
    op_s = OP_NONE;
    if (bus.tick && !bus.edit_en) begin
      op_s = OP_UP;
    end else if (bus.carry_in) begin
      op_s = OP_UP;
    end else if (bus.borrow_in) begin
      op_s = OP_DOWN;
    end else if (bus.ofs_valid) begin
      op_s = bus.ofs_neg ? OP_OFS_SUB : OP_OFS_ADD;
`ifdef UNIT_MOD_COUNTER_HALF12_EN
    end else if (bus.edit_en && bus.half_toggle) begin
      op_s = OP_HALF;
`endif
    end else if (bus.edit_en && bus.inc) begin
      op_s = bus.digit_sel ? OP_TENS_INC : OP_ONES_INC;
    end else if (bus.edit_en && bus.dec) begin
      op_s = bus.digit_sel ? OP_TENS_DEC : OP_ONES_DEC;
    end else begin
      op_s = OP_NONE;
    end
  end

  // Stage 1 register: op code plus the operands the execute stage needs.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r     <= OP_NONE;
      ofs_r    <= '0;
`ifdef UNIT_MOD_COUNTER_HALF12_EN
      mode12_r <= 1'b0;
`endif
    end else begin
      op_r     <= op_s;
      ofs_r    <= bus.ofs_val;
`ifdef UNIT_MOD_COUNTER_HALF12_EN
      mode12_r <= bus.mode12;
`endif
    end
  end

  // Candidate results for every edit operation, all on the current value.
  always_comb begin
    v_s      = XW'(value_r);
    ofs_x_s  = XW'(ofs_r);
    ones_x_s = XW'(ones_s);
    base_s   = XW'(tens_s) * RADIX_X;
    sum_s    = v_s + ofs_x_s;
    // Highest ones digit still below MODULUS under the current tens digit.
    room_s   = MOD_X - ONE_X - base_s;
    lim_s    = (room_s > NINE_X) ? NINE_X : room_s;
    // Number of tens that fit on top of the ones digit below MODULUS.
    tdk_s    = (MOD_X - ONE_X - ones_x_s) / RADIX_X;
    ones_inc_s = base_s + ((ones_x_s == lim_s) ? ZERO_X : (ones_x_s + ONE_X));
    ones_dec_s = base_s + ((ones_x_s == ZERO_X) ? lim_s : (ones_x_s - ONE_X));
    tens_inc_s = ((v_s + RADIX_X) < MOD_X) ? (v_s + RADIX_X) : ones_x_s;
    if (v_s >= RADIX_X) begin
      tens_dec_s = v_s - RADIX_X;
    end else if (ones_x_s < MOD_X) begin
      tens_dec_s = ones_x_s + (tdk_s * RADIX_X);
    end else begin
      tens_dec_s = v_s;
    end
  end

`ifdef UNIT_MOD_COUNTER_HALF12_EN
  // 12-hour helpers: step within the current half, or jump to the other half.
  always_comb begin
    half_lo_s   = (v_s < HALF_X) ? ZERO_X : HALF_X;
    half_hi_s   = half_lo_s + HALF_X - ONE_X;
    half_inc_s  = (v_s == half_hi_s) ? half_lo_s : (v_s + ONE_X);
    half_dec_s  = (v_s == half_lo_s) ? half_hi_s : (v_s - ONE_X);
    half_flip_s = (v_s < HALF_X) ? (v_s + HALF_X) : (v_s - HALF_X);
  end
`endif

  // Stage 2: next value and pulses from the registered op code.
  always_comb begin
    nxt_s    = v_s;
    carry_s  = 1'b0;
    borrow_s = 1'b0;
    err_s    = 1'b0;
    case (op_r)
      OP_UP: begin
        if (v_s == (MOD_X - ONE_X)) begin
          nxt_s   = ZERO_X;
          carry_s = 1'b1;
        end else begin
          nxt_s = v_s + ONE_X;
        end
      end
      OP_DOWN: begin
        if (v_s == ZERO_X) begin
          nxt_s    = MOD_X - ONE_X;
          borrow_s = 1'b1;
        end else begin
          nxt_s = v_s - ONE_X;
        end
      end
      OP_OFS_ADD: begin
        if (ofs_x_s >= MOD_X) begin
          err_s = 1'b1;
        end else if (sum_s >= MOD_X) begin
          nxt_s   = sum_s - MOD_X;
          carry_s = 1'b1;
        end else begin
          nxt_s = sum_s;
        end
      end
      OP_OFS_SUB: begin
        if (ofs_x_s >= MOD_X) begin
          err_s = 1'b1;
        end else if (v_s < ofs_x_s) begin
          nxt_s    = v_s + MOD_X - ofs_x_s;
          borrow_s = 1'b1;
        end else begin
          nxt_s = v_s - ofs_x_s;
        end
      end
`ifdef UNIT_MOD_COUNTER_HALF12_EN
      OP_ONES_INC: nxt_s = mode12_r ? half_inc_s : ones_inc_s;
      OP_ONES_DEC: nxt_s = mode12_r ? half_dec_s : ones_dec_s;
      OP_TENS_INC: nxt_s = mode12_r ? half_inc_s : tens_inc_s;
      OP_TENS_DEC: nxt_s = mode12_r ? half_dec_s : tens_dec_s;
      OP_HALF:     nxt_s = half_flip_s;
`else
      OP_ONES_INC: nxt_s = ones_inc_s;
      OP_ONES_DEC: nxt_s = ones_dec_s;
      OP_TENS_INC: nxt_s = tens_inc_s;
      OP_TENS_DEC: nxt_s = tens_dec_s;
`endif
      default: nxt_s = v_s;
    endcase
  end

  // Stage 2 register: value and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r  <= '0;
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      value_r  <= nxt_s[WIDTH-1:0];
      carry_r  <= carry_s;
      borrow_r <= borrow_s;
      err_r    <= err_s;
    end
  end

  assign bus.value      = value_r;
  assign bus.carry_out  = carry_r;
  assign bus.borrow_out = borrow_r;
  assign bus.err        = err_r;

`ifdef UNIT_MOD_COUNTER_HALF12_EN
  assign unused_s = &{1'b0, nxt_s[XW-1:WIDTH]};
`else
  assign unused_s = &{1'b0, nxt_s[XW-1:WIDTH], bus.mode12, bus.half_toggle};
`endif

endmodule

// File: tb/tb_unit_mod_counter.sv
// Directed self-checking bench for unit_mod_counter (MODULUS 24 and 60).
module tb_unit_mod_counter;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  unit_mod_counter_if #(.WIDTH(7)) bus24 ();
  unit_mod_counter_if #(.WIDTH(7)) bus60 ();

  unit_mod_counter #(.MODULUS(24), .WIDTH(7)) dut24 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus24)
  );

  unit_mod_counter #(.MODULUS(60), .WIDTH(7)) dut60 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus60)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear24();
    bus24.tick = 1'b0; bus24.edit_en = 1'b0; bus24.inc = 1'b0; bus24.dec = 1'b0;
    bus24.digit_sel = 1'b0; bus24.carry_in = 1'b0; bus24.borrow_in = 1'b0;
    bus24.ofs_valid = 1'b0; bus24.ofs_neg = 1'b0; bus24.ofs_val = 7'd0;
    bus24.mode12 = 1'b0; bus24.half_toggle = 1'b0;
  endtask

  task automatic clear60();
    bus60.tick = 1'b0; bus60.edit_en = 1'b0; bus60.inc = 1'b0; bus60.dec = 1'b0;
    bus60.digit_sel = 1'b0; bus60.carry_in = 1'b0; bus60.borrow_in = 1'b0;
    bus60.ofs_valid = 1'b0; bus60.ofs_neg = 1'b0; bus60.ofs_val = 7'd0;
    bus60.mode12 = 1'b0; bus60.half_toggle = 1'b0;
  endtask

  // One request held for one edge, then released; returns after the result edge.
  task automatic step24(input logic t, input logic ci, input logic bi,
                        input logic ov, input logic on, input logic [6:0] oval,
                        input logic e, input logic i, input logic d,
                        input logic ds, input logic m, input logic h);
    bus24.tick = t; bus24.carry_in = ci; bus24.borrow_in = bi;
    bus24.ofs_valid = ov; bus24.ofs_neg = on; bus24.ofs_val = oval;
    bus24.edit_en = e; bus24.inc = i; bus24.dec = d; bus24.digit_sel = ds;
    bus24.mode12 = m; bus24.half_toggle = h;
    @(negedge clk);
    clear24();
    @(negedge clk);
  endtask

  task automatic ofs24(input logic neg, input logic [6:0] val);
    step24(1'b0, 1'b0, 1'b0, 1'b1, neg, val, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic edit24(input logic is_inc, input logic ds, input logic m12);
    step24(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, is_inc, !is_inc, ds, m12, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set24(input logic [6:0] v);
    do_reset();
    ofs24(1'b0, v);
  endtask

  task automatic check24(input string tag, input int v, input int c, input int b, input int e);
    check({tag, "_value"},  int'(bus24.value),      v);
    check({tag, "_carry"},  int'(bus24.carry_out),  c);
    check({tag, "_borrow"}, int'(bus24.borrow_out), b);
    check({tag, "_err"},    int'(bus24.err),        e);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    clear24();
    clear60();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check24("reset", 0, 0, 0, 0);
    check("reset60_value", int'(bus60.value), 0);

    // Count 0..23 then wrap with one carry pulse
    for (int i = 1; i <= 24; i++) begin
      step24(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("tick_value", int'(bus24.value), i % 24);
      check("tick_carry", int'(bus24.carry_out), (i == 24) ? 1 : 0);
    end
    @(negedge clk);
    check24("carry_one_cycle", 0, 0, 0, 0);

    // Back-to-back ticks over three consecutive edges
    bus24.tick = 1'b1;
    repeat (3) @(negedge clk);
    bus24.tick = 1'b0;
    @(negedge clk);
    check24("b2b_tick", 3, 0, 0, 0);

    // Borrow wrap 0 -> 23
    do_reset();
    step24(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check24("borrow_wrap", 23, 0, 1, 0);

    // Ones edit from 21: 22, 23, 20 then dec -> 23
    set24(7'd21);
    check24("set21", 21, 0, 0, 0);
    edit24(1'b1, 1'b0, 1'b0);
    check24("ones_inc1", 22, 0, 0, 0);
    edit24(1'b1, 1'b0, 1'b0);
    check24("ones_inc2", 23, 0, 0, 0);
    edit24(1'b1, 1'b0, 1'b0);
    check24("ones_inc3", 20, 0, 0, 0);
    edit24(1'b0, 1'b0, 1'b0);
    check24("ones_dec", 23, 0, 0, 0);
    // Tens dec with value >= 10: 23 -> 13
    edit24(1'b0, 1'b1, 1'b0);
    check24("tens_dec_ge10", 13, 0, 0, 0);

    // Tens edit
    set24(7'd15);
    edit24(1'b1, 1'b1, 1'b0);
    check24("tens_inc_wrap", 5, 0, 0, 0);
    edit24(1'b1, 1'b1, 1'b0);
    check24("tens_inc_fit", 15, 0, 0, 0);
    set24(7'd3);
    edit24(1'b0, 1'b1, 1'b0);
    check24("tens_dec_3", 23, 0, 0, 0);

    // Edits ignored outside edit mode
    set24(7'd7);
    step24(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check24("inc_no_edit", 7, 0, 0, 0);

    // Tens dec on MODULUS=60: 7 -> 57
    do_reset();
    bus60.ofs_valid = 1'b1; bus60.ofs_val = 7'd7;
    @(negedge clk);
    clear60();
    @(negedge clk);
    check("m60_set7", int'(bus60.value), 7);
    bus60.edit_en = 1'b1; bus60.dec = 1'b1; bus60.digit_sel = 1'b1;
    @(negedge clk);
    clear60();
    @(negedge clk);
    check("m60_tens_dec", int'(bus60.value), 57);
    check("m60_tens_dec_borrow", int'(bus60.borrow_out), 0);

    // Offsets
    set24(7'd20);
    ofs24(1'b0, 7'd7);
    check24("ofs_add", 3, 1, 0, 0);
    ofs24(1'b1, 7'd5);
    check24("ofs_sub", 22, 0, 1, 0);
    ofs24(1'b0, 7'd30);
    check24("ofs_reject30", 22, 0, 0, 1);
    @(negedge clk);
    check24("err_one_cycle", 22, 0, 0, 0);
    ofs24(1'b1, 7'd24);
    check24("ofs_reject24", 22, 0, 0, 1);
    ofs24(1'b0, 7'd1);
    check24("ofs_add_edge", 23, 0, 0, 0);

    // Priority: tick + inc + carry_in -> exactly +1
    set24(7'd5);
    step24(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check24("prio_plus1", 6, 0, 0, 0);
    set24(7'd23);
    step24(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check24("prio_wrap", 0, 1, 0, 0);
    @(negedge clk);
    check24("prio_single", 0, 0, 0, 0);

    // Reset while a tick is pending cancels it
    set24(7'd23);
    bus24.tick = 1'b1;
    @(negedge clk);
    bus24.tick = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check24("rst_cancel", 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    check24("rst_after", 0, 0, 0, 0);

`ifdef UNIT_MOD_COUNTER_HALF12_EN
    set24(7'd11);
    edit24(1'b1, 1'b0, 1'b1);
    check24("h12_inc11", 0, 0, 0, 0);
    set24(7'd23);
    edit24(1'b1, 1'b1, 1'b1);
    check24("h12_inc23", 12, 0, 0, 0);
    set24(7'd12);
    edit24(1'b0, 1'b0, 1'b1);
    check24("h12_dec12", 23, 0, 0, 0);
    set24(7'd5);
    step24(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check24("h12_toggle", 17, 0, 0, 0);
`else
    set24(7'd5);
    step24(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check24("toggle_ignored", 5, 0, 0, 0);
    set24(7'd11);
    edit24(1'b1, 1'b0, 1'b1);
    check24("mode12_ignored", 12, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
